// File: rtl/pulse_det_pkg.sv
// Shared defaults and helpers for the pulse-width detector family.
package pulse_det_pkg;

  localparam int unsigned N_CH_DEFAULT = 4;
  localparam int unsigned W_DEFAULT    = 8;

  // Increment that sticks at 2^w-1; callers cast the result back to w bits.
  function automatic int unsigned sat_inc(input int unsigned v, input int unsigned w);
    int unsigned top;
    top = (32'd1 << w) - 32'd1;
    return (v >= top) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/pulse_width_channel.sv
// One channel: run-length counter plus trailing-edge width qualification.
module pulse_width_channel
  import pulse_det_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         act,
  input  logic [W-1:0] min_len,
  input  logic [W-1:0] max_len,
  output logic         detected,
  output logic [W-1:0] len
);

  logic [W-1:0] cnt;
  logic [W-1:0] lo;

  always_ff @(posedge clk) begin
    if (rst)
      cnt <= '0;
    else if (act)
      cnt <= W'(sat_inc(32'(cnt), W));
    else
      cnt <= '0;
  end

  // A zero minimum still demands at least one active sample.
  assign lo = (min_len == '0) ? W'(1) : min_len;

  always_comb begin
    detected = 1'b0;
    len      = cnt;
    if (rst) begin
      len = '0;
    end else if (!act && (cnt != '0) && (cnt >= lo) && (cnt <= max_len)) begin
      detected = 1'b1;
    end
  end

endmodule

// File: rtl/pulse_width_detector.sv
// Multi-channel pulse-width detector with shared polarity and width window.
module pulse_width_detector
  import pulse_det_pkg::*;
#(
  parameter int unsigned N_CH = N_CH_DEFAULT,
  parameter int unsigned W    = W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   a,
  input  logic              pol,
  input  logic [W-1:0]      min_len,
  input  logic [W-1:0]      max_len,
  output logic [N_CH-1:0]   detected,
  output logic [N_CH*W-1:0] pulse_len
);

  logic [N_CH-1:0] act;

  assign act = a ^ {N_CH{pol}};

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_width_channel #(.W(W)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .act      (act[i]),
      .min_len  (min_len),
      .max_len  (max_len),
      .detected (detected[i]),
      .len      (pulse_len[i*W +: W])
    );
  end

endmodule
